// File: rtl/alu_acc_seq_if.sv
// Command and result channels of the accumulator stage, grouped as one bundle.
// The master drives commands and consumes results; the slave is the accumulator.
interface alu_acc_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             overflow;
  logic             ovf_sticky;
  logic             zero;
  logic             negative;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, acc, overflow, ovf_sticky, zero, negative, op_count
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, acc, overflow, ovf_sticky, zero, negative, op_count
  );
endinterface

// File: rtl/alu_acc_seq.sv
// Sequential add/sub accumulator: accept a command, execute it in one cycle,
// then hold the result and flags until the consumer takes them.
module alu_acc_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_acc_seq_if.slave      bus
);
  localparam int S = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             ovf_reg;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;

  // Result of the latched command against the current accumulator.
  always_comb begin
    sum_next  = acc_reg + data_reg;
    diff_next = acc_reg - data_reg;
    acc_next  = acc_reg;
    ovf_next  = 1'b0;
    case (op_reg)
      OP_LOAD: begin
        acc_next = data_reg;
      end
      OP_ADD: begin
        acc_next = sum_next;
        ovf_next = (acc_reg[S] == data_reg[S]) && (sum_next[S] != acc_reg[S]);
      end
      OP_SUB: begin
        acc_next = diff_next;
        ovf_next = (acc_reg[S] != data_reg[S]) && (diff_next[S] != acc_reg[S]);
      end
      default: begin
        acc_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= 2'b00;
      data_reg      <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      sticky_reg    <= 1'b0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            op_reg    <= bus.in_op;
            data_reg  <= bus.in_data;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          acc_reg <= acc_next;
          ovf_reg <= ovf_next;
          if (op_reg == OP_CLEAR) begin
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
          end else begin
            sticky_reg <= sticky_reg | ovf_next;
            // Saturate rather than wrap so a long run still reads as "many".
            if (cnt_reg != {CNT_W{1'b1}}) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          out_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.out_valid  = out_valid_reg;
  assign bus.acc        = acc_reg;
  assign bus.overflow   = ovf_reg;
  assign bus.ovf_sticky = sticky_reg;
  assign bus.op_count   = cnt_reg;
  assign bus.zero       = (acc_reg == '0);
  assign bus.negative   = acc_reg[S];

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for the accumulator stage; a narrow 2-bit counter makes the
// saturation corner reachable in a handful of commands.
module tb_alu_acc_seq;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SUB   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_acc_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_acc_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_res(input string tag, input logic [7:0] a, input logic ov,
                            input logic st, input logic [1:0] cnt);
    check({tag, "_acc"}, bus.acc, a);
    check({tag, "_ovf"}, bus.overflow, ov);
    check({tag, "_sticky"}, bus.ovf_sticky, st);
    check({tag, "_zero"}, bus.zero, a == 8'h00);
    check({tag, "_neg"}, bus.negative, a[7]);
    check({tag, "_cnt"}, bus.op_count, cnt);
  endtask

  // Issue one command with out_ready high and verify the accept/resp timing.
  task automatic do_op(input logic [1:0] op, input logic [7:0] data);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data   = data;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("exec_out_valid", bus.out_valid, 0);
    check("exec_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("resp_out_valid", bus.out_valid, 1);
    @(negedge clk);
    check("idle_out_valid", bus.out_valid, 0);
    check("idle_in_ready", bus.in_ready, 1);
    $display("op=%0d data=%02h -> acc=%02h ovf=%0b sticky=%0b cnt=%0d",
             op, data, bus.acc, bus.overflow, bus.ovf_sticky, bus.op_count);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = LOAD;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    expect_res("rst", 8'h00, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    do_op(LOAD, 8'h7F); expect_res("load7f", 8'h7F, 1'b0, 1'b0, 2'd1);
    do_op(ADD, 8'h01);  expect_res("add_ovf", 8'h80, 1'b1, 1'b1, 2'd2);
    do_op(LOAD, 8'h80); expect_res("load80", 8'h80, 1'b0, 1'b1, 2'd3);
    do_op(SUB, 8'h01);  expect_res("sub_ovf", 8'h7F, 1'b1, 1'b1, 2'd3);
    do_op(LOAD, 8'h05); expect_res("load05", 8'h05, 1'b0, 1'b1, 2'd3);
    do_op(SUB, 8'h05);  expect_res("sub_zero", 8'h00, 1'b0, 1'b1, 2'd3);
    do_op(CLEAR, 8'hAA); expect_res("clear1", 8'h00, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < 5; i++) begin
      do_op(LOAD, 8'h40 + 8'(i));
      expect_res("sat_load", 8'h40 + 8'(i), 1'b0, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    do_op(ADD, 8'h44);   expect_res("add_ovf2", 8'h88, 1'b1, 1'b1, 2'd3);
    do_op(CLEAR, 8'h00); expect_res("clear2", 8'h00, 1'b0, 1'b0, 2'd0);
    do_op(SUB, 8'h01);   expect_res("sub_neg", 8'hFF, 1'b0, 1'b0, 2'd1);
    do_op(ADD, 8'h01);   expect_res("add_wrap", 8'h00, 1'b0, 1'b0, 2'd2);

    // Backpressure: hold the response while a competing command pulses.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = ADD;
    bus.in_data   = 8'h10;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_op   = LOAD;
    bus.in_data = 8'h99;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_acc", bus.acc, 8'h10);
      check("bp_cnt", bus.op_count, 2'd3);
    end
    $display("backpressure held acc=%02h", bus.acc);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = ADD;
    bus.in_data   = 8'h01;
    @(negedge clk);
    check("bp_release_idle", bus.in_ready, 1);
    check("bp_release_ov", bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_exec", bus.in_ready, 0);
    @(negedge clk);
    check("bp_next_resp", bus.out_valid, 1);
    expect_res("bp_next", 8'h11, 1'b0, 1'b0, 2'd3);
    @(negedge clk);
    $display("post-backpressure add acc=%02h", bus.acc);

    // Reset while ADD 0x22 is in EXEC: the command must vanish.
    bus.in_valid = 1'b1;
    bus.in_op    = ADD;
    bus.in_data  = 8'h22;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_exec_state", bus.in_ready, 0);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_ov", bus.out_valid, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ov", bus.out_valid, 0);
      check("post_rst_ready", bus.in_ready, 1);
    end
    expect_res("post_rst", 8'h00, 1'b0, 1'b0, 2'd0);
    $display("reset mid-exec acc=%02h", bus.acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
